// File: rtl/step_transport.sv
// Drum sequencer transport: step counter, tempo, STOPPED/PLAYING/PAUSED control
// and a TRACKS x STEPS pattern that fires one-cycle triggers at each step entry.
module step_transport #(
    parameter int STEPS          = 8,
    parameter int TRACKS         = 4,
    parameter int PERIOD_W       = 24,
    parameter int DEFAULT_PERIOD = 12500000,
    parameter int MIN_PERIOD     = 6250000,
    parameter int MAX_PERIOD     = 16000000,
    parameter int PERIOD_STEP    = 250000
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       play,
    input  logic                       stop,
    input  logic                       pause,
    input  logic                       tempo_up,
    input  logic                       tempo_down,
    input  logic                       edit_we,
    input  logic [$clog2(TRACKS)-1:0]  edit_track,
    input  logic [$clog2(STEPS)-1:0]   edit_step,
    input  logic                       edit_val,
    output logic [$clog2(STEPS)-1:0]   beatNum,
    output logic                       beatClk,
    output logic [TRACKS-1:0]          trig,
    output logic                       playing,
    output logic [PERIOD_W-1:0]        period
);
    localparam int SW = $clog2(STEPS);
    localparam int TW = $clog2(TRACKS);

    localparam logic [PERIOD_W-1:0] DEF_P  = PERIOD_W'(DEFAULT_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P  = PERIOD_W'(MAX_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P  = PERIOD_W'(1);
    localparam logic [PERIOD_W:0]   MIN_X  = (PERIOD_W+1)'(MIN_PERIOD);
    localparam logic [PERIOD_W:0]   MAX_X  = (PERIOD_W+1)'(MAX_PERIOD);
    localparam logic [PERIOD_W:0]   STEP_X = (PERIOD_W+1)'(PERIOD_STEP);
    localparam logic [TW:0]         TRK_X  = (TW+1)'(TRACKS);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [PERIOD_W-1:0]         counter_q, counter_d;
    logic [PERIOD_W-1:0]         active_q, active_d;
    logic [PERIOD_W-1:0]         period_q, period_d;
    logic [SW-1:0]               beat_q, beat_d;
    logic                        beat_clk_q, beat_clk_d;
    logic [TRACKS-1:0]           trig_q, trig_d;
    logic                        playing_q, playing_d;
    logic [TRACKS-1:0][STEPS-1:0] pattern_q;

    logic                        step_end_s;
    logic [SW-1:0]               next_beat_s;
    logic [PERIOD_W-1:0]         counter_inc_s;
    logic [PERIOD_W:0]           period_x_s, up_x_s, dn_x_s;
    logic                        edit_ok_s;

    function automatic logic [TRACKS-1:0] column(input logic [TRACKS-1:0][STEPS-1:0] pat,
                                                 input logic [SW-1:0] step);
        logic [TRACKS-1:0] col;
        col = '0;
        for (int t = 0; t < TRACKS; t++) begin
            col[t] = pat[t][step];
        end
        return col;
    endfunction

    assign step_end_s    = (counter_q == (active_q - ONE_P));
    assign next_beat_s   = beat_q + SW'(1);
    assign counter_inc_s = counter_q + ONE_P;
    assign period_x_s    = {1'b0, period_q};
    assign up_x_s        = period_x_s - STEP_X;
    assign dn_x_s        = period_x_s + STEP_X;
    assign edit_ok_s     = edit_we && ({1'b0, edit_track} < TRK_X);

    // Transport state machine and step timing next-state
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        beat_d     = beat_q;
        beat_clk_d = beat_clk_q;
        active_d   = active_q;
        trig_d     = '0;
        case (state_q)
            ST_STOPPED: begin
                counter_d  = '0;
                beat_d     = '0;
                beat_clk_d = 1'b1;
                if (stop) begin
                    state_d = ST_STOPPED;
                end else if (play) begin
                    state_d  = ST_PLAYING;
                    active_d = period_q;
                    trig_d   = column(pattern_q, '0);
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            ST_PLAYING: begin
                if (stop) begin
                    state_d    = ST_STOPPED;
                    counter_d  = '0;
                    beat_d     = '0;
                    beat_clk_d = 1'b1;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (step_end_s) begin
                    counter_d  = '0;
                    beat_d     = next_beat_s;
                    beat_clk_d = 1'b1;
                    active_d   = period_q;
                    trig_d     = column(pattern_q, next_beat_s);
                end else begin
                    counter_d  = counter_inc_s;
                    beat_clk_d = (counter_inc_s < (active_q >> 1));
                end
            end
            ST_PAUSED: begin
                // Resume keeps the frozen counter, so the step finishes its remainder
                if (stop) begin
                    state_d    = ST_STOPPED;
                    counter_d  = '0;
                    beat_d     = '0;
                    beat_clk_d = 1'b1;
                end else if (play) begin
                    state_d = ST_PLAYING;
                end else begin
                    state_d = ST_PAUSED;
                end
            end
            default: begin
                state_d    = ST_STOPPED;
                counter_d  = '0;
                beat_d     = '0;
                beat_clk_d = 1'b1;
            end
        endcase
        playing_d = (state_d == ST_PLAYING);
    end

    // Tempo adjust with clamping, computed one bit wider to avoid wrap
    always_comb begin
        period_d = period_q;
        if (tempo_up && !tempo_down) begin
            if (period_x_s < (MIN_X + STEP_X)) begin
                period_d = MIN_P;
            end else begin
                period_d = up_x_s[PERIOD_W-1:0];
            end
        end else if (tempo_down && !tempo_up) begin
            if (dn_x_s > MAX_X) begin
                period_d = MAX_P;
            end else begin
                period_d = dn_x_s[PERIOD_W-1:0];
            end
        end else begin
            period_d = period_q;
        end
    end

    // State, timing, tempo and pattern registers
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOPPED;
            counter_q  <= '0;
            active_q   <= DEF_P;
            period_q   <= DEF_P;
            beat_q     <= '0;
            beat_clk_q <= 1'b1;
            trig_q     <= '0;
            playing_q  <= 1'b0;
            pattern_q  <= '0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            active_q   <= active_d;
            period_q   <= period_d;
            beat_q     <= beat_d;
            beat_clk_q <= beat_clk_d;
            trig_q     <= trig_d;
            playing_q  <= playing_d;
            if (edit_ok_s) begin
                pattern_q[edit_track][edit_step] <= edit_val;
            end
        end
    end

    assign beatNum = beat_q;
    assign beatClk = beat_clk_q;
    assign trig    = trig_q;
    assign playing = playing_q;
    assign period  = period_q;

endmodule

// File: tb/tb_step_transport.sv
// Self-checking bench for step_transport: a vector table for the basic loop plus
// hand-written sequences for pause, tempo, command priority and async reset.
module tb_step_transport;
    localparam int CMD_NONE  = 0;
    localparam int CMD_PLAY  = 16;
    localparam int CMD_STOP  = 8;
    localparam int CMD_PAUSE = 4;
    localparam int CMD_UP    = 2;
    localparam int CMD_DN    = 1;

    typedef struct {
        logic [4:0] cmd;
        logic [2:0] beat;
        logic       bclk;
        logic [3:0] trig;
        logic       pl;
        logic [7:0] per;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       play, stop, pause, tempo_up, tempo_down;
    logic       edit_we;
    logic [1:0] edit_track;
    logic [2:0] edit_step;
    logic       edit_val;
    logic [2:0] beat_num;
    logic       beat_clk;
    logic [3:0] trig;
    logic       playing;
    logic [7:0] period;

    int   checks;
    int   errors;
    bit   exp_pat [4][8];
    vec_t tv[$];
    vec_t exp_q[$];

    step_transport #(
        .STEPS(8), .TRACKS(4), .PERIOD_W(8), .DEFAULT_PERIOD(8),
        .MIN_PERIOD(4), .MAX_PERIOD(12), .PERIOD_STEP(2)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .play(play), .stop(stop), .pause(pause),
        .tempo_up(tempo_up), .tempo_down(tempo_down), .edit_we(edit_we),
        .edit_track(edit_track), .edit_step(edit_step), .edit_val(edit_val),
        .beatNum(beat_num), .beatClk(beat_clk), .trig(trig), .playing(playing),
        .period(period)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic int colv(input int s);
        int r;
        r = 0;
        for (int t = 0; t < 4; t++) begin
            if (exp_pat[t][s]) r |= (1 << t);
        end
        return r;
    endfunction

    function automatic vec_t mk(input int cmd, input int b, input int c, input int t,
                                input int p, input int per);
        vec_t v;
        v.cmd  = 5'(cmd);
        v.beat = 3'(b);
        v.bclk = 1'(c);
        v.trig = 4'(t);
        v.pl   = 1'(p);
        v.per  = 8'(per);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        exp_q.push_back(v);
        {play, stop, pause, tempo_up, tempo_down} = v.cmd;
        @(posedge clk);
        #1;
        {play, stop, pause, tempo_up, tempo_down} = 5'b00000;
        e = exp_q.pop_front();
        chk({nm, "_beat"},    32'(beat_num), 32'(e.beat));
        chk({nm, "_beatClk"}, 32'(beat_clk), 32'(e.bclk));
        chk({nm, "_trig"},    32'(trig),     32'(e.trig));
        chk({nm, "_playing"}, 32'(playing),  32'(e.pl));
        chk({nm, "_period"},  32'(period),   32'(e.per));
    endtask

    task automatic run(input int cmd, input int b, input int c, input int t,
                       input int p, input int per, input string nm);
        apply(mk(cmd, b, c, t, p, per), nm);
    endtask

    task automatic write_cell(input int t, input int s, input bit v);
        edit_we    = 1'b1;
        edit_track = 2'(t);
        edit_step  = 3'(s);
        edit_val   = v;
        @(posedge clk);
        #1;
        edit_we = 1'b0;
        exp_pat[t][s] = v;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_beat"},    32'(beat_num), 32'd0);
        chk({nm, "_beatClk"}, 32'(beat_clk), 32'd1);
        chk({nm, "_trig"},    32'(trig),     32'd0);
        chk({nm, "_playing"}, 32'(playing),  32'd0);
        chk({nm, "_period"},  32'(period),   32'd8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        {play, stop, pause, tempo_up, tempo_down} = 5'b00000;
        edit_we = 1'b0; edit_track = 2'd0; edit_step = 3'd0; edit_val = 1'b0;
        for (int t = 0; t < 4; t++)
            for (int s = 0; s < 8; s++) exp_pat[t][s] = 1'b0;

        // Reset values before any clock edge
        #2;
        chk_reset_vals("reset_noclk");
        @(posedge clk);
        #1;
        reset = 1'b0;

        write_cell(0, 0, 1'b1);
        write_cell(0, 4, 1'b1);
        write_cell(2, 1, 1'b1);

        // One full loop plus wrap: position j after play, step j/8, counter j%8
        tv.push_back(mk(CMD_PLAY, 0, 1, colv(0), 1, 8));
        for (int j = 1; j <= 64; j++) begin
            tv.push_back(mk(CMD_NONE, (j / 8) % 8, ((j % 8) < 4) ? 1 : 0,
                            ((j % 8) == 0) ? colv((j / 8) % 8) : 0, 1, 8));
        end
        for (int i = 0; i < tv.size(); i++) apply(tv[i], "loop");

        // Pause at counter 3, hold, resume: entry 5 edges after resume
        for (int c = 1; c <= 3; c++) run(CMD_NONE, 0, 1, 0, 1, 8, "pre_pause");
        run(CMD_PAUSE, 0, 1, 0, 0, 8, "pause");
        for (int i = 0; i < 10; i++) run(CMD_NONE, 0, 1, 0, 0, 8, "paused");
        run(CMD_PLAY, 0, 1, 0, 1, 8, "resume");
        for (int c = 4; c <= 7; c++) run(CMD_NONE, 0, 0, 0, 1, 8, "resume_cnt");
        run(CMD_NONE, 1, 1, 4'b0100, 1, 8, "resume_entry");

        // Tempo up x3 mid-step: current step keeps 8, following steps last 4
        run(CMD_UP, 1, 1, 0, 1, 6, "up1");
        run(CMD_UP, 1, 1, 0, 1, 4, "up2");
        run(CMD_UP, 1, 1, 0, 1, 4, "up_clamp");
        for (int c = 4; c <= 7; c++) run(CMD_NONE, 1, 0, 0, 1, 4, "old_step");
        for (int s = 2; s < 4; s++) begin
            run(CMD_NONE, s, 1, 0, 1, 4, "short_entry");
            run(CMD_NONE, s, 1, 0, 1, 4, "short_hi");
            run(CMD_NONE, s, 0, 0, 1, 4, "short_lo");
            run(CMD_NONE, s, 0, 0, 1, 4, "short_lo");
        end
        run(CMD_NONE, 4, 1, 4'b0001, 1, 4, "step4_trig");

        // Tempo down x5 to the upper clamp, crossing a step entry
        run(CMD_DN, 4, 1, 0, 1, 6, "dn1");
        run(CMD_DN, 4, 0, 0, 1, 8, "dn2");
        run(CMD_DN, 4, 0, 0, 1, 10, "dn3");
        run(CMD_DN, 5, 1, 0, 1, 12, "dn4");
        run(CMD_DN, 5, 1, 0, 1, 12, "dn_clamp");

        // Command priority
        run(CMD_STOP | CMD_PLAY, 0, 1, 0, 0, 12, "stop_wins");
        run(CMD_UP | CMD_DN, 0, 1, 0, 0, 12, "up_dn_both");
        run(CMD_PLAY, 0, 1, 4'b0001, 1, 12, "play2");
        run(CMD_NONE, 0, 1, 0, 1, 12, "play2_run");
        run(CMD_PAUSE | CMD_PLAY, 0, 1, 0, 0, 12, "pause_wins");
        run(CMD_STOP, 0, 1, 0, 0, 12, "stop_paused");
        run(CMD_PAUSE, 0, 1, 0, 0, 12, "pause_stopped");
        run(CMD_NONE, 0, 1, 0, 0, 12, "stopped_idle");

        // Run into step 1 second half at period 12, then async reset mid-step
        run(CMD_PLAY, 0, 1, 4'b0001, 1, 12, "play3");
        for (int c = 1; c <= 11; c++) run(CMD_NONE, 0, (c < 6) ? 1 : 0, 0, 1, 12, "run12");
        run(CMD_NONE, 1, 1, 4'b0100, 1, 12, "step1_12");
        for (int c = 1; c <= 8; c++) run(CMD_NONE, 1, (c < 6) ? 1 : 0, 0, 1, 12, "run12b");
        #3;
        reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int t = 0; t < 4; t++)
            for (int s = 0; s < 8; s++) exp_pat[t][s] = 1'b0;
        run(CMD_PLAY, 0, 1, colv(0), 1, 8, "play_cleared");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/step_transport.md
# step_transport

Transport and pattern scheduler for the drum sequencer's step clock. Owns the step counter and tempo, runs a STOPPED/PLAYING/PAUSED state machine from front-panel pulses, and holds a TRACKS x STEPS pattern. At the start of each step it emits one-cycle trigger pulses to the drum voices. It replaces free-running beat generation: all step timing downstream derives from `beatNum`, `beatClk` and `trig`.

## Interface
- `STEPS`, 8: steps per pattern loop (power of two, ≥2).
- `TRACKS`, 4: drum tracks.
- `PERIOD_W`, 24: width of the period registers.
- `DEFAULT_PERIOD`, 12500000: step length in clocks after reset.
- `MIN_PERIOD`, 6250000: lower clamp for the step length (≥4).
- `MAX_PERIOD`, 16000000: upper clamp for the step length (< 2^PERIOD_W).
- `PERIOD_STEP`, 250000: tempo adjust increment.
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `play`, `stop`, `pause`  in  1 each  single-cycle command pulses.
- `tempo_up`, `tempo_down`  in  1 each  single-cycle pulses that shorten or lengthen the step.
- `edit_we`  in  1  pattern write enable.
- `edit_track`  in  $clog2(TRACKS)  track to write.
- `edit_step`  in  $clog2(STEPS)  step to write.
- `edit_val`  in  1  bit value to write.
- `beatNum`  out  $clog2(STEPS)  current step.
- `beatClk`  out  1  high for the first half of each step, low for the second half.
- `trig`  out  TRACKS  one-cycle pulse, bit t = `pattern[t][new step]`.
- `playing`  out  1  high in PLAYING.
- `period`  out  PERIOD_W  programmed step length.

## Operation
- Reset values (asynchronous):
  - state STOPPED; `counter` = 0; `beatNum` = 0; `beatClk` = 1; `trig` = 0; `playing` = 0.
  - `period` = `active_period` = DEFAULT_PERIOD.
  - Pattern all zero.
- Command priority when pulses coincide: stop > pause > play.
- STOPPED:
  - counter, `beatNum` and `beatClk` held at their reset values.
  - `play` → PLAYING. The same edge loads `active_period` ← `period` and sets `trig` ← pattern column for step 0.
  - `pause` is ignored.
- PLAYING:
  - `counter` increments each cycle.
  - `beatClk` is registered and equals (`counter` < `active_period`>>1).
  - When `counter` == `active_period`−1:
    - `counter` ← 0;
    - `beatNum` ← `beatNum`+1, wrapping STEPS−1 → 0;
    - `beatClk` ← 1;
    - `active_period` ← `period`;
    - `trig` ← column for the new step.
  - `pause` → PAUSED. `stop` → STOPPED, with counter, `beatNum` and `beatClk` returned to reset values.
  - `play` is ignored.
- PAUSED:
  - counter, `beatNum`, `beatClk` and `active_period` frozen; `trig` = 0.
  - `play` → PLAYING and resumes counting from the frozen counter. No trigger fires on resume.
  - `stop` → STOPPED.
- `trig` is 0 in every cycle except a step-entry edge.
- Tempo:
  - `tempo_up`: `period` ← max(`period`−PERIOD_STEP, MIN_PERIOD).
  - `tempo_down`: `period` ← min(`period`+PERIOD_STEP, MAX_PERIOD).
  - Both pulses in the same cycle: no change.
  - Tempo adjusts in any state.
  - A new `period` never alters the step in progress; it takes effect at the next step entry.
  - Arithmetic is done at PERIOD_W+1 bits before the clamp, so there is no wrap.
- Pattern edit:
  - `edit_we` writes `pattern[edit_track][edit_step]` ← `edit_val` on the clock edge, in any state.
  - `edit_track` ≥ TRACKS: the write is ignored.
  - If a write and a step-entry read hit the same cell in the same cycle, `trig` uses the old value.

## Timing
- All outputs are registered. `play` sampled at edge k gives `playing` = 1 and `trig` valid in cycle k+1.
- Each step is exactly `active_period` cycles:
  - `beatClk` high for `active_period`>>1 cycles;
  - `beatClk` low for the remaining cycles (odd periods: low lasts one cycle longer).
- A full loop lasts STEPS × period cycles when the tempo is unchanged.
- Resume from PAUSED: the step ends `active_period`−`counter` cycles after the `play` edge.
- `reset` asserted mid-step drives all outputs to reset values immediately, with no clock edge needed. Deassertion is synchronized externally.

## Test plan
Parameters for all scenarios: DEFAULT_PERIOD=8, MIN_PERIOD=4, MAX_PERIOD=12, PERIOD_STEP=2, STEPS=8, TRACKS=4.

1. Reset, no clocks → `beatNum`=0, `beatClk`=1, `trig`=0, `playing`=0, `period`=8.
2. Write track0 steps 0 and 4, track2 step 1, then pulse `play` → `trig`=4'b0001 one cycle after `play`. 8 cycles later `beatNum`=1 and `trig`=4'b0100. `beatClk` runs 4 high / 4 low. Step 4 gives `trig`=4'b0001. The wrap to step 0 occurs 64 cycles after the first trigger, with `trig`=4'b0001.
3. Pause at `counter`=3, hold 10 cycles, then `play` → `beatNum` and `beatClk` frozen while paused, no `trig` on resume, next step entry 5 cycles after the resume edge.
4. `tempo_up` ×3 mid-step → `period` goes 6, 4, 4 (clamped). The current step still lasts 8 cycles; the next step lasts 4 (2 high / 2 low). Then `tempo_down` ×5 → `period`=12 (clamped).
5. `stop`+`play` together while PLAYING → STOPPED, `beatNum`=0. `pause`+`play` together while PLAYING → PAUSED. `pause` while STOPPED → no change.
6. Assert `reset` between clock edges mid-step, with the pattern non-zero → outputs take reset values before the next edge. After release, `play` gives `trig`=0 (pattern cleared).
